// File: rtl/my_mem_arbiter.sv
// Two-master arbiter for a single shared data memory with a 1-cycle
// synchronous read. Master A is the CPU, master B is a secondary master.
// Grants are round-robin. A master holding lock keeps the grant, but only for a
// bounded number of cycles while the other master is waiting.
module my_mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_lock,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_lock,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_ctrl_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK);

  // One-hot owner encoding, so each grant output is a flop bit and never glitches.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t           state_q, state_d, arb_state;
  logic             ptr_q, ptr_d;          // 0: A wins a tie, 1: B wins a tie
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             a_rvalid_q, a_rvalid_d;
  logic             b_rvalid_q, b_rvalid_d;

  assign a_gnt    = state_q[0];
  assign b_gnt    = state_q[1];
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign rdata    = mem_data_in;

  // Fair pick used whenever the current grant ends (or no one owns the bus).
  always_comb begin
    arb_state = IDLE;
    if (a_req && b_req) begin
      arb_state = ptr_q ? OWN_B : OWN_A;
    end else if (a_req) begin
      arb_state = OWN_A;
    end else if (b_req) begin
      arb_state = OWN_B;
    end
  end

  // Next owner, lock bookkeeping and tie-break pointer update.
  always_comb begin
    state_d    = arb_state;
    lock_cnt_d = '0;
    ptr_d      = ptr_q;
    case (state_q)
      OWN_A: begin
        if (a_req && a_lock) begin
          if (!b_req) begin
            state_d = OWN_A;
          end else if (lock_cnt_q == LOCK_LIMIT) begin
            state_d = OWN_B;
          end else begin
            state_d    = OWN_A;
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
          end
        end
      end
      OWN_B: begin
        if (b_req && b_lock) begin
          if (!a_req) begin
            state_d = OWN_B;
          end else if (lock_cnt_q == LOCK_LIMIT) begin
            state_d = OWN_A;
          end else begin
            state_d    = OWN_B;
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
    // The master granted most recently loses the next tie.
    if (state_d == OWN_A) begin
      ptr_d = 1'b1;
    end else if (state_d == OWN_B) begin
      ptr_d = 1'b0;
    end
  end

  // A read executes when the owner still requests it in its grant cycle.
  // Data returns one cycle later.
  always_comb begin
    a_rvalid_d = a_gnt & a_req & ~a_we;
    b_rvalid_d = b_gnt & b_req & ~b_we;
  end

  // Memory port driven by the registered owner.
  // A request dropped by its grant cycle performs no write.
  always_comb begin
    mem_ctrl_write = 1'b0;
    mem_addr       = '0;
    mem_data_out   = '0;
    if (a_gnt) begin
      mem_ctrl_write = a_req & a_we;
      mem_addr       = a_addr;
      mem_data_out   = a_wdata;
    end else if (b_gnt) begin
      mem_ctrl_write = b_req & b_we;
      mem_addr       = b_addr;
      mem_data_out   = b_wdata;
    end
  end

  // Control state registers. Reset drops grants and pending read valids at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      lock_cnt_q <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

endmodule

// File: tb/tb_my_mem_arbiter.sv
// Testbench for my_mem_arbiter: directed stimulus with a small synchronous memory.
// The stimulus queues the expected grant cycles and read returns. A monitor on
// the falling clock edge pops each queue and compares whenever the arbiter
// grants or returns read data.
module tb_my_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_req = 1'b0, a_lock = 1'b0, a_we = 1'b0;
  logic       b_req = 1'b0, b_lock = 1'b0, b_we = 1'b0;
  logic [7:0] a_addr = 8'h00, a_wdata = 8'h00, b_addr = 8'h00, b_wdata = 8'h00;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid, mem_ctrl_write;
  logic [7:0] rdata, mem_addr, mem_data_out;
  logic [7:0] mem_data_in = 8'h00;
  logic [7:0] mem [256];

  typedef struct packed {
    logic       a;
    logic       b;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } gnt_t;

  typedef struct packed {
    logic       a;
    logic       b;
    logic [7:0] data;
  } rd_t;

  gnt_t gq[$];
  rd_t  rq[$];
  gnt_t g;
  rd_t  r;
  int   n_chk  = 0;
  int   n_fail = 0;

  my_mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rdata(rdata), .mem_ctrl_write(mem_ctrl_write), .mem_addr(mem_addr),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  // Shared memory: 1-cycle synchronous read, write on the enabled cycle.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    mem[8'h10] <= 8'h33;
    mem[8'h11] <= 8'h44;
  end

  always @(posedge clk) begin
    if (mem_ctrl_write) mem[mem_addr] <= mem_data_out;
    mem_data_in <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pg(input logic a, input logic b, input logic wr,
                    input logic [7:0] addr, input logic [7:0] data);
    gnt_t e;
    e.a = a; e.b = b; e.wr = wr; e.addr = addr; e.data = data;
    gq.push_back(e);
  endtask

  task automatic pr(input logic a, input logic b, input logic [7:0] data);
    rd_t e;
    e.a = a; e.b = b; e.data = data;
    rq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_gnt"}, 32'(a_gnt), 32'd0);
    check({tag, "_b_gnt"}, 32'(b_gnt), 32'd0);
    check({tag, "_a_rvalid"}, 32'(a_rvalid), 32'd0);
    check({tag, "_b_rvalid"}, 32'(b_rvalid), 32'd0);
    check({tag, "_mem_write"}, 32'(mem_ctrl_write), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst");
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drain(input string tag);
    repeat (3) tick();
    check({tag, "_gnt_queue_empty"}, 32'(gq.size()), 32'd0);
    check({tag, "_rd_queue_empty"}, 32'(rq.size()), 32'd0);
    gq.delete();
    rq.delete();
  endtask

  // Monitor: compares grant cycles, idle memory-port state and read returns.
  always @(negedge clk) begin
    if (!rst) begin
      check("gnt_exclusive", 32'(a_gnt & b_gnt), 32'd0);
      if (a_gnt || b_gnt) begin
        if (gq.size() == 0) begin
          check("unexpected_gnt", 32'({a_gnt, b_gnt}), 32'd0);
        end else begin
          g = gq.pop_front();
          check("a_gnt", 32'(a_gnt), 32'(g.a));
          check("b_gnt", 32'(b_gnt), 32'(g.b));
          check("mem_ctrl_write", 32'(mem_ctrl_write), 32'(g.wr));
          if (g.wr) begin
            check("mem_addr", 32'(mem_addr), 32'(g.addr));
            check("mem_data_out", 32'(mem_data_out), 32'(g.data));
          end
        end
      end else begin
        check("idle_write", 32'(mem_ctrl_write), 32'd0);
        check("idle_addr", 32'(mem_addr), 32'd0);
        check("idle_data", 32'(mem_data_out), 32'd0);
      end
      if (a_rvalid || b_rvalid) begin
        if (rq.size() == 0) begin
          check("unexpected_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
        end else begin
          r = rq.pop_front();
          check("a_rvalid", 32'(a_rvalid), 32'(r.a));
          check("b_rvalid", 32'(b_rvalid), 32'(r.b));
          check("rdata", 32'(rdata), 32'(r.data));
        end
      end
    end
  end

  initial begin
    #1;
    do_reset();

    // A lone read of 0x10: a real grant, then a dummy grant after the drop.
    pg(1, 0, 0, 8'h00, 8'h00); pg(1, 0, 0, 8'h00, 8'h00);
    pr(1, 0, 8'h33);
    a_req = 1; a_we = 0; a_addr = 8'h10;
    tick(); tick();
    a_req = 0;
    drain("t1");

    // Both requesters held continuously, so grants alternate starting with A.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pg(1, 0, 0, 8'h00, 8'h00); pg(0, 1, 0, 8'h00, 8'h00);
    end
    pg(1, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      pr(1, 0, 8'h33); pr(0, 1, 8'h44);
    end
    a_req = 1; a_addr = 8'h10; b_req = 1; b_addr = 8'h11;
    repeat (7) tick();
    a_req = 0; b_req = 0;
    drain("t2");

    // A locks while B waits: A gets 1+4 cycles, then B gets one, then A again.
    do_reset();
    repeat (5) pg(1, 0, 0, 8'h00, 8'h00);
    pg(0, 1, 0, 8'h00, 8'h00);
    pg(1, 0, 0, 8'h00, 8'h00); pg(1, 0, 0, 8'h00, 8'h00);
    repeat (5) pr(1, 0, 8'h33);
    pr(0, 1, 8'h44); pr(1, 0, 8'h33);
    a_req = 1; a_lock = 1; a_addr = 8'h10; b_req = 1; b_addr = 8'h11;
    repeat (7) tick();
    b_req = 0;
    tick();
    a_req = 0; a_lock = 0;
    drain("t3");

    // B writes 0x5A to 0x20, then A reads the new value back.
    pg(0, 1, 1, 8'h20, 8'h5A); pg(1, 0, 0, 8'h00, 8'h00); pg(1, 0, 0, 8'h00, 8'h00);
    pr(1, 0, 8'h5A);
    b_req = 1; b_we = 1; b_addr = 8'h20; b_wdata = 8'h5A;
    tick();
    a_req = 1; a_we = 0; a_addr = 8'h20;
    tick();
    b_req = 0; b_we = 0;
    tick();
    a_req = 0;
    drain("t4");

    // B write request withdrawn before its grant cycle: grant only, no write.
    pg(0, 1, 0, 8'h00, 8'h00);
    b_req = 1; b_we = 1; b_addr = 8'h30; b_wdata = 8'hA5;
    tick();
    b_req = 0; b_we = 0;
    drain("t6");
    check("t6_mem_untouched", 32'(mem[8'h30]), 32'd0);

    // Reset arrives in A's read grant cycle, before rvalid.
    // Afterwards A must win the first tie again.
    a_req = 1; a_we = 0; a_addr = 8'h10;
    tick();
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_rst");
    a_req = 0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    pg(1, 0, 0, 8'h00, 8'h00); pg(0, 1, 0, 8'h00, 8'h00); pg(1, 0, 0, 8'h00, 8'h00);
    pr(1, 0, 8'h33); pr(0, 1, 8'h44);
    a_req = 1; a_addr = 8'h10; b_req = 1; b_addr = 8'h11;
    repeat (3) tick();
    a_req = 0; b_req = 0;
    drain("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
